// File: rtl/alu_iterative.sv
// Multi-cycle EX-stage unit: single-cycle logic/arith ops plus iterative shift-add MUL and restoring DIV.
// Optional feature macro: ALU_SIGNED_MULDIV_EN (two's-complement MUL/DIV); default build is unsigned.
module alu_iterative #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero,
    output logic             illegal_op
);

`ifdef ALU_SIGNED_MULDIV_EN
    localparam logic SIGNED_MD = 1'b1;
`else
    localparam logic SIGNED_MD = 1'b0;
`endif

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_a;
    logic               neg_b;
    logic               md_ovf;
    logic [WIDTH-1:0]   opnd_r;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg2_if(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return neg_if(v, SIGNED_MD && v[WIDTH-1]);
    endfunction

    logic signed [WIDTH-1:0] rs_s;
    logic signed [WIDTH-1:0] rt_s;
    logic [WIDTH-1:0]        add_sum;
    logic [WIDTH-1:0]        sub_dif;
    logic [WIDTH-1:0]        alu_lo;
    logic                    alu_ovf;
    logic                    alu_ill;

    assign rs_s    = rs_data;
    assign rt_s    = rt_data;
    assign add_sum = rs_data + rt_data;
    assign sub_dif = rs_data - rt_data;

    always_comb begin
        alu_lo  = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (alu_op)
            OP_AND:  alu_lo = rs_data & rt_data;
            OP_OR:   alu_lo = rs_data | rt_data;
            OP_XOR:  alu_lo = rs_data ^ rt_data;
            OP_NOR:  alu_lo = ~(rs_data | rt_data);
            OP_ADD: begin
                alu_lo  = add_sum;
                alu_ovf = (rs_data[WIDTH-1] == rt_data[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != rs_data[WIDTH-1]);
            end
            OP_SUB: begin
                alu_lo  = sub_dif;
                alu_ovf = (rs_data[WIDTH-1] != rt_data[WIDTH-1]) &&
                          (sub_dif[WIDTH-1] != rs_data[WIDTH-1]);
            end
            OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, (rs_s < rt_s)};
            OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, (rs_data < rt_data)};
            OP_MUL, OP_DIV: alu_lo = '0;
            default: alu_ill = 1'b1;
        endcase
    end

    // One iteration step: MUL shifts the partial product right, DIV shifts the remainder left.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;
    logic [2*WIDTH-1:0] fin_prod;
    logic [WIDTH-1:0]   fin_lo;
    logic [WIDTH-1:0]   fin_hi;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_r} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_r};
        if (is_div) begin
            nxt_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
        end else begin
            nxt_hi = mul_sum[WIDTH:1];
            nxt_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
        fin_prod = neg2_if({nxt_hi, nxt_lo}, neg_a ^ neg_b);
        if (is_div) begin
            fin_lo = neg_if(nxt_lo, neg_a ^ neg_b);
            fin_hi = neg_if(nxt_hi, neg_a);
        end else begin
            fin_lo = fin_prod[WIDTH-1:0];
            fin_hi = fin_prod[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt        <= '0;
            is_div     <= 1'b0;
            neg_a      <= 1'b0;
            neg_b      <= 1'b0;
            md_ovf     <= 1'b0;
            result_lo  <= '0;
            result_hi  <= '0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
            div_zero   <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (start) begin
                        if (alu_op == OP_MUL) begin
                            state  <= S_RUN;
                            busy   <= 1'b1;
                            cnt    <= CNT_W'(WIDTH);
                            is_div <= 1'b0;
                            neg_a  <= SIGNED_MD && rs_data[WIDTH-1];
                            neg_b  <= SIGNED_MD && rt_data[WIDTH-1];
                            md_ovf <= 1'b0;
                            opnd_r <= magnitude(rs_data);
                            acc_lo <= magnitude(rt_data);
                            acc_hi <= '0;
                        end else if (alu_op == OP_DIV && rt_data == '0) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            result_lo  <= '1;
                            result_hi  <= rs_data;
                            zero       <= 1'b0;
                            overflow   <= 1'b0;
                            div_zero   <= 1'b1;
                            illegal_op <= 1'b0;
                        end else if (alu_op == OP_DIV) begin
                            state  <= S_RUN;
                            busy   <= 1'b1;
                            cnt    <= CNT_W'(WIDTH);
                            is_div <= 1'b1;
                            neg_a  <= SIGNED_MD && rs_data[WIDTH-1];
                            neg_b  <= SIGNED_MD && rt_data[WIDTH-1];
                            md_ovf <= SIGNED_MD && (rs_data == MOST_NEG) && (rt_data == '1);
                            opnd_r <= magnitude(rt_data);
                            acc_lo <= magnitude(rs_data);
                            acc_hi <= '0;
                        end else begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            result_lo  <= alu_lo;
                            result_hi  <= '0;
                            zero       <= (alu_lo == '0);
                            overflow   <= alu_ovf;
                            div_zero   <= 1'b0;
                            illegal_op <= alu_ill;
                        end
                    end
                end
                S_RUN: begin
                    cnt    <= cnt - CNT_W'(1);
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    if (cnt == CNT_W'(1)) begin
                        state      <= S_DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        result_lo  <= fin_lo;
                        result_hi  <= fin_hi;
                        zero       <= (fin_lo == '0);
                        overflow   <= md_ovf;
                        div_zero   <= 1'b0;
                        illegal_op <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_iterative.sv
// Scoreboard bench for alu_iterative: driver queues hand-computed results, monitor checks each done pulse.
module tb_alu_iterative;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    alu_op = 4'b0000;
    logic [W-1:0]  rs_data = '0;
    logic [W-1:0]  rt_data = '0;
    logic          busy, done, zero, overflow, div_zero, illegal_op;
    logic [W-1:0]  result_lo, result_hi;

    alu_iterative #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .alu_op(alu_op),
        .rs_data(rs_data), .rt_data(rt_data), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .zero(zero),
        .overflow(overflow), .div_zero(div_zero), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         z;
        logic         o;
        logic         dz;
        logic         il;
        int           lat;
        int           acc;
        int           id;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   vec_id = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Issue one request once the unit is free; the expected response is queued before the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] elo, input logic [W-1:0] ehi,
                         input logic ez, input logic eo, input logic edz, input logic eil,
                         input int lat, input bit push);
        exp_t e;
        int   n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) check("busy_timeout", {63'd0, busy}, 64'd0);
        vec_id++;
        if (push) begin
            e.lo = elo; e.hi = ehi; e.z = ez; e.o = eo; e.dz = edz; e.il = eil;
            e.lat = lat; e.acc = cyc + 1; e.id = vec_id;
            sbq.push_back(e);
        end
        start   = 1'b1;
        alu_op  = op;
        rs_data = a;
        rt_data = b;
        @(posedge clk); #1;
        start   = 1'b0;
        alu_op  = 4'b1111;
        rs_data = $urandom;
        rt_data = $urandom;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (!rst && done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", {63'd0, done}, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    check($sformatf("v%0d_lo", e.id), 64'(result_lo), 64'(e.lo));
                    check($sformatf("v%0d_hi", e.id), 64'(result_hi), 64'(e.hi));
                    check($sformatf("v%0d_zero", e.id), 64'(zero), 64'(e.z));
                    check($sformatf("v%0d_ovf", e.id), 64'(overflow), 64'(e.o));
                    check($sformatf("v%0d_divzero", e.id), 64'(div_zero), 64'(e.dz));
                    check($sformatf("v%0d_illegal", e.id), 64'(illegal_op), 64'(e.il));
                    check($sformatf("v%0d_latency", e.id), 64'(cyc - e.acc + 1), 64'(e.lat));
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int n;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_lo", 64'(result_lo), 64'd0);
        check("rst_hi", 64'(result_hi), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_divzero", 64'(div_zero), 64'd0);
        check("rst_illegal", 64'(illegal_op), 64'd0);

        // op,   a,            b,            lo,           hi,           z  o  dz il lat push
        issue(4'b0010, 32'd5,        32'd7,        32'd12,       32'd0, 0, 0, 0, 0, 1, 1);
        issue(4'b0110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0, 1, 0, 0, 1, 1);
        issue(4'b0110, 32'd3,        32'd3,        32'd0,        32'd0, 1, 0, 0, 0, 1, 1);
        issue(4'b0010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 32'd0, 0, 1, 0, 0, 1, 1);
        issue(4'b0110, 32'h80000000, 32'd1,        32'h7FFFFFFF, 32'd0, 0, 1, 0, 0, 1, 1);
        issue(4'b0000, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 32'd0, 0, 0, 0, 0, 1, 1);
        issue(4'b0001, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 32'd0, 0, 0, 0, 0, 1, 1);
        issue(4'b0011, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 32'd0, 0, 0, 0, 0, 1, 1);
        issue(4'b0100, 32'hF0000000, 32'h0000000F, 32'h0FFFFFF0, 32'd0, 0, 0, 0, 0, 1, 1);
        issue(4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        32'd0, 0, 0, 0, 0, 1, 1);
        issue(4'b0101, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0, 1, 0, 0, 0, 1, 1);
        issue(4'b1111, 32'd5,        32'd6,        32'd0,        32'd0, 1, 0, 0, 1, 1, 1);
        issue(4'b1010, 32'd5,        32'd6,        32'd0,        32'd0, 1, 0, 0, 1, 1, 1);

        issue(4'b1001, 32'd100,      32'd7,        32'd14,       32'd2, 0, 0, 0, 0, W + 1, 1);
        issue(4'b1001, 32'd9,        32'd0,        32'hFFFFFFFF, 32'd9, 0, 0, 1, 0, 1, 1);
        issue(4'b1000, 32'h00010000, 32'h00010000, 32'd0,        32'd1, 1, 0, 0, 0, W + 1, 1);
`ifdef ALU_SIGNED_MULDIV_EN
        issue(4'b1000, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'hFFFFFFFF, 0, 0, 0, 0, W + 1, 1);
        issue(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        0, 0, 0, 0, W + 1, 1);
        issue(4'b1001, 32'hFFFFFFFF, 32'h10,       32'd0,        32'hFFFFFFFF, 1, 0, 0, 0, W + 1, 1);
        issue(4'b1001, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 0, 0, W + 1, 1);
        issue(4'b1000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 32'hFFFFFFFF, 0, 0, 0, 0, W + 1, 1);
        issue(4'b1001, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        0, 1, 0, 0, W + 1, 1);
`else
        issue(4'b1000, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'd1,        0, 0, 0, 0, W + 1, 1);
        issue(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFE, 0, 0, 0, 0, W + 1, 1);
        issue(4'b1001, 32'hFFFFFFFF, 32'h10,       32'h0FFFFFFF, 32'd15,       0, 0, 0, 0, W + 1, 1);
        issue(4'b1001, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1, 0, 0, 0, W + 1, 1);
`endif

        // A start while MUL is running must be dropped entirely.
        issue(4'b1000, 32'd3, 32'd4, 32'd12, 32'd0, 0, 0, 0, 0, W + 1, 1);
        repeat (4) begin @(posedge clk); #1; end
        check("busy_in_run", 64'(busy), 64'd1);
        start = 1'b1; alu_op = 4'b0010; rs_data = 32'd5; rt_data = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;

        // Reset in the middle of a DIV: no done, everything back to reset values.
        issue(4'b1001, 32'd1000, 32'd3, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_lo", 64'(result_lo), 64'd0);
        check("abort_hi", 64'(result_hi), 64'd0);
        check("abort_zero", 64'(zero), 64'd0);
        repeat (40) begin @(posedge clk); #1; end

        issue(4'b0010, 32'd5,   32'd7, 32'd12, 32'd0, 0, 0, 0, 0, 1, 1);
        issue(4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0, 0, W + 1, 1);

        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 64'(sbq.size()), 64'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("hold_lo", 64'(result_lo), 64'd14);
        check("hold_hi", 64'(result_hi), 64'd2);
        check("hold_done", 64'(done), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
